seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 Parameter SCAN_DIV_BITS, default 18, digit dwell = 2^SCAN_DIV_BITS clocks (minimum 6).
REQ-003 Parameter GUARD, default 16, anode-off guard clocks at the start of each dwell.
REQ-004 clock_100Mhz  input  1  system clock; reset is asynchronous and active-high.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 load  input  1  single-cycle request to latch new display content.
REQ-007 digits_in  input  4*NUM_DIGITS  hex nibble per digit; digit k = bits [4k+3:4k].
REQ-008 blank_in  input  NUM_DIGITS  1 = digit k dark.
REQ-009 dp_in  input  NUM_DIGITS  1 = decimal point k lit.
REQ-010 brightness  input  4  PWM duty level; 0 = dark, 15 = 15/16 on-time.
REQ-011 ready  output  1  high when no update is pending.
REQ-012 seg  output  7  segments {a,b,c,d,e,f,g} = seg[6:0], active-low.
REQ-013 dp  output  1  decimal point, active-low.
REQ-014 an  output  NUM_DIGITS  anodes, active-low, at most one low.
REQ-015 frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-016 Prescaler SHALL count 0..2^SCAN_DIV_BITS-1 and wrap; digit index SHALL increment on wrap, returning from NUM_DIGITS-1 to 0.
REQ-017 frame_done SHALL pulse on the cycle the index wraps NUM_DIGITS-1 -> 0.
REQ-018 load SHALL be accepted on any cycle: digits_in/blank_in/dp_in captured into a pending buffer, ready dropping the next cycle.
REQ-019 Update FSM states IDLE, PENDING; IDLE->PENDING on load; PENDING->IDLE at frame boundary, when pending copies into the active buffer.
REQ-020 load while PENDING SHALL overwrite pending (latest wins); load coinciding with the commit SHALL leave the new data pending and ready low.
REQ-021 Active content SHALL change only at a frame boundary; no torn frames.
REQ-022 Digit drive: an[index] low only when prescaler >= GUARD, blank bit clear, and brightness > prescaler[SCAN_DIV_BITS-1 -: 4]; otherwise all an high.
REQ-023 seg SHALL carry the hex decode (0-F) of the active nibble; dp = ~dp_in bit; both forced high when the anode is off.
REQ-024 Hex encoding: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-025 seg, dp, an SHALL be registered; one clock latency from prescaler/index state to pins.
REQ-026 brightness SHALL be sampled live (no buffering); changes apply on the next clock.

Reset
REQ-027 On reset: prescaler 0, index 0, FSM IDLE, active and pending buffers all-zero digits, blank all ones, dp all zeros.
REQ-028 On reset: an all ones, seg 7'b1111111, dp 1, ready 1, frame_done 0.
REQ-029 Reset mid-frame or while PENDING SHALL discard pending data without committing it.

Structure
REQ-030 Package seg7_pkg SHALL hold the 16-entry hex-to-segment table, segment/anode polarity constants, and the FSM state typedef.
REQ-031 Sub-module seg7_hex_decode (4-bit in, 7-bit active-low out, combinational) SHALL implement REQ-024.

Verification (SCAN_DIV_BITS=6, GUARD=4, NUM_DIGITS=4)
REQ-032 Reset, brightness=15, no load -> an stays 4'b1111, seg 1111111, ready 1, frame_done every 256 clocks.
REQ-033 load digits_in=16'h3210, blank=0, dp=4'b0010 -> after next frame_done: digit 0 seg 0000001, digit 1 seg 1001111 with dp=0, an low during dwell clocks 4..59 (brightness=15).
REQ-034 Two loads (16'h1111 then 16'hABCD) in one frame -> only ABCD displayed; 1111 never appears; ready high after the commit.
REQ-035 load on the frame_done cycle -> old data shown one more frame, new data committed at the following boundary.
REQ-036 brightness=0 -> an all high; brightness=8 -> an low only during dwell clocks 4..31.
REQ-037 reset asserted while PENDING -> outputs return to reset values immediately; after release, no commit of the discarded data.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex glyph table, pin polarities, update FSM states.
// No logic lives here.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic       AN_OFF  = 1'b1;
    localparam logic       AN_ON   = 1'b0;
    localparam logic       DP_OFF  = 1'b1;

    // Active-low {a,b,c,d,e,f,g}; entry n sits at index n (F is listed first).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } upd_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low segment pattern.
// Latency: combinational; backpressure: none.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver with guard-banded PWM dimming and frame-synchronous content update.
// Latency: pins lag scan state by one clock; backpressure: ready low while an update waits for the frame boundary.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV_BITS = 18,
    parameter int GUARD         = 16
) (
    input  logic                    clock_100Mhz,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [3:0]              brightness,
    output logic                    ready,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [SCAN_DIV_BITS-1:0]   presc;
    logic [IDX_W-1:0]           idx;
    logic                       frame_end;
    logic                       commit;
    upd_state_t                 state, state_nxt;

    logic [NUM_DIGITS-1:0][3:0] pnd_digits, act_digits;
    logic [NUM_DIGITS-1:0]      pnd_blank, act_blank;
    logic [NUM_DIGITS-1:0]      pnd_dp, act_dp;

    logic [6:0]                 cur_seg;
    logic                       drive;

    assign frame_end  = (&presc) && (idx == LAST_IDX);
    assign frame_done = frame_end;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (&presc)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // A load landing on the commit cycle keeps the FSM pending for the next frame.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (load) state_nxt = ST_PENDING;
            ST_PENDING: if (frame_end && !load) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready  = (state == ST_IDLE);
        commit = frame_end && (state == ST_PENDING);
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            pnd_digits <= '0;
            pnd_blank  <= '1;
            pnd_dp     <= '0;
            act_digits <= '0;
            act_blank  <= '1;
            act_dp     <= '0;
        end else begin
            if (commit) begin
                act_digits <= pnd_digits;
                act_blank  <= pnd_blank;
                act_dp     <= pnd_dp;
            end
            if (load) begin
                pnd_digits <= digits_in;
                pnd_blank  <= blank_in;
                pnd_dp     <= dp_in;
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble (act_digits[idx]),
        .seg_n  (cur_seg)
    );

    // PWM compares the top four prescaler bits so duty steps are 1/16 of the dwell.
    assign drive = (presc >= SCAN_DIV_BITS'(GUARD))
                && !act_blank[idx]
                && (brightness > presc[SCAN_DIV_BITS-1 -: 4]);

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            an  <= {NUM_DIGITS{AN_OFF}};
            seg <= SEG_OFF;
            dp  <= DP_OFF;
        end else begin
            an <= {NUM_DIGITS{AN_OFF}};
            if (drive)
                an[idx] <= AN_ON;
            seg <= drive ? cur_seg : SEG_OFF;
            dp  <= drive ? ~act_dp[idx] : DP_OFF;
        end
    end

endmodule
